// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/data requesters, the arbiter and the memory model.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment that drives requests and plays the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_stall;
  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D).
// Only one transaction is in flight at a time. D has priority, but once D has
// won MAX_D_STREAK grants in a row, a waiting I gets the next grant. A
// transaction that sees no mem_ready within TIMEOUT cycles is aborted. The
// abort still returns a zero-data done pulse and sets the sticky err flag.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q;
  logic              mem_req_q, mem_we_q, i_done_q, d_done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;
  logic [SW-1:0]     streak_q;
  logic [TW-1:0]     tmo_q;

  // A requester whose done pulse is showing this cycle is not re-granted.
  // This prevents a duplicate access while its req is still held high.
  logic i_elig, d_elig, d_win;
  assign i_elig = bus.i_req & ~i_done_q;
  assign d_elig = bus.d_req & ~d_done_q;
  assign d_win  = d_elig & ~(i_elig & (streak_q == STREAK_MAX));

  // Arbitration FSM; every output except the stalls is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            tmo_q       <= '0;
            if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
          end else if (i_elig) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
            streak_q    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready || tmo_q == TMO_LAST) begin
            // Normal completion or abort. An abort returns zero data, and a
            // store always returns zero.
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (!bus.mem_ready) err_q <= 1'b1;
            if (state_q == BUSY_I) begin
              i_done_q  <= 1'b1;
              i_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end else begin
              d_done_q  <= 1'b1;
              d_rdata_q <= (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.i_stall   = bus.i_req & ~i_done_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes the expected grants and
// done data into queues. A monitor pops them and compares whenever the DUT
// shows a grant or a done pulse. A responder process plays the memory with a
// programmable latency.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
  grant_t      exp_g[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int tests = 0;
  int fails = 0;
  int lat = 0;            // cycles of mem_req before mem_ready; <0 = never
  logic [31:0] rbase = '0; // memory read data = rbase ^ address
  bit stray = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_g(logic we, logic [31:0] addr, logic [31:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata;
    exp_g.push_back(g);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for 0:i_done 1:d_done 2:mem_req. n counts the negedges seen,
  // including the one on which the signal is found.
  task automatic wait_sig(input int which, output int n);
    logic s;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      s = (which == 0) ? bus.i_done : (which == 1) ? bus.d_done : bus.mem_req;
      if (s) return;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL wait_timeout: signal %0d not seen after %0d cycles", which, n);
        return;
      end
    end
  endtask

  // memory model
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hFFFF_0000 ^ 32'(cnt);
      if (bus.mem_req) begin
        cnt++;
        if (lat >= 0 && cnt == lat + 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rbase ^ bus.mem_addr;
        end
      end else begin
        cnt = 0;
        if (stray) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 32'hBAD0_BAD0;
          stray = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic prev;
    grant_t g;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_req && !prev) begin
          if (exp_g.size() == 0) begin
            tests++; fails++;
            $display("FAIL grant: unexpected grant addr %h we %b", bus.mem_addr, bus.mem_we);
          end else begin
            g = exp_g.pop_front();
            check("grant_we", 32'(bus.mem_we), 32'(g.we));
            check("grant_addr", bus.mem_addr, g.addr);
            if (g.we) check("grant_wdata", bus.mem_wdata, g.wdata);
          end
        end
        if (bus.i_done) begin
          if (exp_i.size() == 0) begin
            tests++; fails++;
            $display("FAIL i_done: unexpected pulse, i_rdata %h", bus.i_rdata);
          end else check("i_rdata", bus.i_rdata, exp_i.pop_front());
        end
        if (bus.d_done) begin
          if (exp_d.size() == 0) begin
            tests++; fails++;
            $display("FAIL d_done: unexpected pulse, d_rdata %h", bus.d_rdata);
          end else check("d_rdata", bus.d_rdata, exp_d.pop_front());
        end
        check("i_stall", 32'(bus.i_stall), 32'(bus.i_req & ~bus.i_done));
        check("d_stall", 32'(bus.d_stall), 32'(bus.d_req & ~bus.d_done));
      end
      prev = bus.mem_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // 1: reset values, then reset while BUSY_D
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_i_done", 32'(bus.i_done), 0);
    check("rst_d_done", 32'(bus.d_done), 0);
    check("rst_err", 32'(bus.err), 0);
    tick(); reset = 1'b0;
    lat = -1;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h180;
    push_g(1'b0, 32'h180, 32'h0);
    wait_sig(2, n);
    #2 reset = 1'b1;
    #1 check("rst_busy_mem_req", 32'(bus.mem_req), 0);
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_busy_no_d_done", 32'(bus.d_done), 0);
    end
    check("rst_busy_err", 32'(bus.err), 0);

    // 2: single fetch, memory answers 3 cycles after mem_req
    lat = 3; rbase = 32'hDEADBEEF ^ 32'h40;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    push_g(1'b0, 32'h40, 32'h0);
    exp_i.push_back(32'hDEADBEEF);
    wait_sig(0, n);
    check("t2_latency", 32'(n), 6);
    tick(); bus.i_req = 1'b0;

    // 3: simultaneous requests; D first, I granted in D's done cycle
    lat = 0; rbase = 32'h1357_2468;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    push_g(1'b0, 32'h100, 32'h0);
    push_g(1'b0, 32'h80, 32'h0);
    exp_d.push_back(32'h1357_2468 ^ 32'h100);
    exp_i.push_back(32'h1357_2468 ^ 32'h80);
    wait_sig(1, n);
    check("t3_d_latency", 32'(n), 3);
    tick(); bus.d_req = 1'b0;
    @(negedge clk);
    check("t3_i_mem_req", 32'(bus.mem_req), 1);
    check("t3_i_mem_addr", bus.mem_addr, 32'h80);
    wait_sig(0, n);
    tick(); bus.i_req = 1'b0;

    // 4: four stores build the D streak; I then wins once, then D again
    lat = 1; rbase = 32'h55AA_55AA;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.d_addr = 32'h300 + 32'(4 * k);
      bus.d_wdata = 32'hA000 + 32'(k);
      push_g(1'b1, 32'h300 + 32'(4 * k), 32'hA000 + 32'(k));
      exp_d.push_back(32'h0);
      wait_sig(1, n);
      tick();
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    bus.d_addr = 32'h310; bus.d_wdata = 32'hA004;
    push_g(1'b0, 32'h500, 32'h0);
    push_g(1'b1, 32'h310, 32'hA004);
    exp_i.push_back(32'h55AA_55AA ^ 32'h500);
    exp_d.push_back(32'h0);
    wait_sig(0, n);
    tick(); bus.i_req = 1'b0;
    wait_sig(1, n);
    tick(); bus.d_req = 1'b0; bus.d_we = 1'b0;

    // 5: no mem_ready -> abort after 8 busy cycles, err sticks
    lat = -1;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    push_g(1'b0, 32'h200, 32'h0);
    exp_d.push_back(32'h0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mem_req) cnt++;
      if (bus.d_done) break;
    end
    check("t5_busy_cycles", 32'(cnt), 8);
    check("t5_err", 32'(bus.err), 1);
    tick(); bus.d_req = 1'b0;
    lat = 2; rbase = 32'h0F0F_0F0F;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    push_g(1'b0, 32'h44, 32'h0);
    exp_i.push_back(32'h0F0F_0F0F ^ 32'h44);
    wait_sig(0, n);
    check("t5_err_sticky", 32'(bus.err), 1);
    tick(); bus.i_req = 1'b0;

    // 6: stray mem_ready while idle is ignored
    tick(); tick();
    stray = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_idle_mem_req", 32'(bus.mem_req), 0);
    end
    lat = 0; rbase = 32'h2468_ACE0;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h120;
    push_g(1'b0, 32'h120, 32'h0);
    exp_d.push_back(32'h2468_ACE0 ^ 32'h120);
    wait_sig(1, n);
    check("t6_latency", 32'(n), 3);
    tick(); bus.d_req = 1'b0;

    repeat (3) @(negedge clk);
    check("end_grants_left", 32'(exp_g.size()), 0);
    check("end_i_left", 32'(exp_i.size()), 0);
    check("end_d_left", 32'(exp_d.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
